// File: rtl/life_sequencer.sv
// life_sequencer: controller for the 4x4 toroidal Life datapath.
// Serially loads a 16-bit seed, then runs generation passes. Each pass is
// 16 strobe cycles, one settle cycle, one commit cycle and one check cycle.
// Outputs are registered decodes of state and cell counter, so every
// visible phase trails the internal state by one clock.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | after reset, waiting for start
//  LOAD   | shifting seed bits into the datapath, cells 0..15
//  SETTLE | one quiet cycle so the datapath's second-phase capture lands
//  COMMIT | one cycle of writeout; counts a generation for eval passes
//  CHECK  | one cycle choosing LOST / DONE / next EVAL
//  EVAL   | evaluating cells 0..15 for the next generation
//  DONE   | stopped on generation limit or halt
//  LOST   | stopped because the datapath reported a dead board
module life_sequencer #(
  parameter int GW    = 8,
  parameter int CELLS = 16
) (
  input  logic          clka,
  input  logic          restart_n,
  input  logic          start,
  input  logic [15:0]   seed,
  input  logic [GW-1:0] gen_limit,
  input  logic          halt,
  input  logic          loseSig,
  output logic          loadData,
  output logic          readData,
  output logic          writeData,
  output logic          writeout,
  output logic          DataIn,
  output logic [3:0]    count,
  output logic [GW-1:0] gen_count,
  output logic          busy,
  output logic          done,
  output logic          lost
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, COMMIT, CHECK, EVAL, DONE, LOST
  } seqState_t;

  seqState_t     state, nextState;
  logic [3:0]    cellCnt;
  logic [15:0]   seedReg;
  logic [GW-1:0] limitReg;
  logic [GW-1:0] genCnt;
  logic          passIsLoad;

  logic          startOk;
  logic          lastCell;

  logic          loadD, readD, writeD, writeoutD, dataInD, busyD, doneD, lostD;
  logic [3:0]    countD;

  assign startOk  = start && (state == IDLE || state == DONE || state == LOST);
  assign lastCell = (cellCnt == 4'(CELLS - 1));

  // State register
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= nextState;
  end

  // Next-state decode; start is only honoured from the idle/terminal states
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE, LOST: if (startOk) nextState = LOAD;
      LOAD, EVAL:       if (lastCell) nextState = SETTLE;
      SETTLE:           nextState = COMMIT;
      COMMIT:           nextState = CHECK;
      CHECK: begin
        if (loseSig)                                     nextState = LOST;
        else if (limitReg != '0 && genCnt == limitReg)   nextState = DONE;
        else if (halt)                                   nextState = DONE;
        else                                             nextState = EVAL;
      end
      default:          nextState = IDLE;
    endcase
  end

  // Run context: captured seed/limit, cell index and generation counter
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      seedReg    <= '0;
      limitReg   <= '0;
      genCnt     <= '0;
      passIsLoad <= 1'b0;
      cellCnt    <= '0;
    end else if (startOk) begin
      seedReg    <= seed;
      limitReg   <= gen_limit;
      genCnt     <= '0;
      passIsLoad <= 1'b1;
      cellCnt    <= '0;
    end else begin
      case (state)
        LOAD, EVAL: cellCnt <= cellCnt + 4'd1;
        COMMIT: begin
          if (!passIsLoad) genCnt <= genCnt + 1'b1;
          passIsLoad <= 1'b0;
          cellCnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  // Output decode from state and cell index (registered below)
  always_comb begin
    loadD     = 1'b0;
    readD     = 1'b0;
    writeD    = 1'b0;
    writeoutD = 1'b0;
    dataInD   = 1'b0;
    countD    = 4'd0;
    busyD     = 1'b0;
    doneD     = 1'b0;
    lostD     = 1'b0;
    case (state)
      LOAD: begin
        loadD   = 1'b1;
        writeD  = 1'b1;
        dataInD = seedReg[cellCnt];
        countD  = cellCnt;
        busyD   = 1'b1;
      end
      EVAL: begin
        readD  = 1'b1;
        writeD = 1'b1;
        countD = cellCnt;
        busyD  = 1'b1;
      end
      SETTLE: begin
        countD = 4'd15;
        busyD  = 1'b1;
      end
      COMMIT: begin
        writeoutD = 1'b1;
        busyD     = 1'b1;
      end
      CHECK: busyD = 1'b1;
      DONE:  doneD = 1'b1;
      LOST:  lostD = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset clears every strobe at once
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      loadData  <= 1'b0;
      readData  <= 1'b0;
      writeData <= 1'b0;
      writeout  <= 1'b0;
      DataIn    <= 1'b0;
      count     <= 4'd0;
      gen_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lost      <= 1'b0;
    end else begin
      loadData  <= loadD;
      readData  <= readD;
      writeData <= writeD;
      writeout  <= writeoutD;
      DataIn    <= dataInD;
      count     <= countD;
      gen_count <= genCnt;
      busy      <= busyD;
      done      <= doneD;
      lost      <= lostD;
    end
  end

endmodule
